// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, key decode and 4-digit BCD entry register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTO_REPEAT_EN.
module keypad_entry #(
    parameter int unsigned CLK_DIV        = 25000,
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter int unsigned REPEAT_DELAY   = 1000,
    parameter int unsigned REPEAT_RATE    = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] bcd,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    // Elaboration-time guard on the configuration.
    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 || CLK_DIV < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1 || REPEAT_DELAY > 65535 ||
        REPEAT_RATE > 65535) begin : g_bad_cfg
        $error("keypad_entry: parameter out of range");
    end

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [PW-1:0] presc;
    logic          tick;
    state_t        state;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [7:0]    count;

    logic [3:0]    low;
    logic          single;
    logic [1:0]    low_idx;
    logic          latched_only;
    logic          latched_row_low;
    logic          released;
    logic [7:0]    count_next;
    logic          count_done;
    logic [3:0]    cur_code;
    logic [15:0]   bcd_next;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        unique case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [15:0] bcd_update(input logic [15:0] b, input logic [3:0] code);
        logic [15:0] nb;
        nb = b;
        if (code <= 4'd9) begin
            nb = {b[11:0], code};
        end else if (code == 4'hF) begin
            nb = 16'h0000;
        end else if (code == 4'hE) begin
            nb = {4'h0, b[15:4]};
        end
        return nb;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign tick = (presc == PW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign col = ~(4'b0001 << col_idx);

    always_comb begin
        low     = ~row_sync;
        single  = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
        low_idx = 2'd0;
        case (low)
            4'b0010: low_idx = 2'd1;
            4'b0100: low_idx = 2'd2;
            4'b1000: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
        latched_only    = (row_sync == ~(4'b0001 << row_idx));
        latched_row_low = ~row_sync[row_idx];
        released        = (row_sync == 4'hF);
        count_next      = count + 8'd1;
        count_done      = (count_next == 8'(DEBOUNCE_TICKS));
        // col_idx is frozen outside SCAN, so it doubles as the latched column.
        cur_code        = key_lookup(row_idx, col_idx);
        bcd_next        = bcd_update(bcd, cur_code);
    end

`ifdef KEYPAD_AUTO_REPEAT_EN
    logic [15:0] rep_cnt;
    logic        rep_armed;
    logic [15:0] rep_next;
    logic        rep_fire;

    always_comb begin
        rep_next = rep_cnt + 16'd1;
        rep_fire = (rep_next == (rep_armed ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY)));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            count     <= 8'd0;
            bcd       <= 16'h0000;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rep_cnt   <= 16'd0;
            rep_armed <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (single) begin
                            row_idx <= low_idx;
                            count   <= 8'd0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (latched_only) begin
                            count <= count_next;
                            if (count_done) begin
                                key_code  <= cur_code;
                                key_valid <= 1'b1;
                                bcd       <= bcd_next;
                                count     <= 8'd0;
                                state     <= HELD;
`ifdef KEYPAD_AUTO_REPEAT_EN
                                rep_cnt   <= 16'd0;
                                rep_armed <= 1'b0;
`endif
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    HELD: begin
                        if (latched_row_low) begin
                            count <= 8'd0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                            if (rep_fire) begin
                                rep_cnt   <= 16'd0;
                                rep_armed <= 1'b1;
                                key_code  <= cur_code;
                                key_valid <= 1'b1;
                                bcd       <= bcd_next;
                            end else begin
                                rep_cnt <= rep_next;
                            end
`endif
                        end else begin
`ifdef KEYPAD_AUTO_REPEAT_EN
                            rep_cnt   <= 16'd0;
                            rep_armed <= 1'b0;
`endif
                            // Other rows in the frozen column are ignored entirely.
                            if (released) begin
                                if (count_done) begin
                                    count   <= 8'd0;
                                    state   <= SCAN;
                                    col_idx <= col_idx + 2'd1;
                                end else begin
                                    count <= count_next;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the multiplexed display path: scans a 4x4 matrix keypad by driving one column low at a time and reading the rows.
- Debounces key presses and decodes them to a 4-bit key code.
- Digit keys are shifted into a 4-digit packed BCD register. The display front end consumes this register directly, so typed digits appear on the 7-segment display.

Parameters:
- CLK_DIV, 25000: system clocks per scan tick (50 MHz -> 2 kHz).
- DEBOUNCE_TICKS, 10: consecutive stable scan ticks required to accept a press or a release (1..255).
- REPEAT_DELAY, 1000: ticks a key is held before the first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 200: ticks between repeats (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- row  input  4  keypad rows, active-low, asynchronous to clk
- col  output 4  keypad column drive, active-low one-hot
- bcd  output 16  entered value {thousands, hundreds, tens, ones}, feeds the display front end
- key_code  output 4  code of the last accepted key
- key_valid  output 1  one-clk pulse per accepted key

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: col=4'b1110, bcd=16'h0000, key_code=4'h0, key_valid=0, state=SCAN, column index=0, prescaler=0, debounce count=0. Reset asserted mid-operation aborts any state immediately.
- Row synchronizer: row passes through a 2-flop synchronizer; only the synchronized value is used. Row synchronizer flops reset to 4'hF.
- Scan tick: 1-clk strobe when the prescaler wraps at CLK_DIV-1. All FSM decisions happen on tick cycles only.
- Column drive: col = ~(1 << column index).
- SCAN state, on each tick:
  - Exactly one synchronized row low: latch row index r and column c, clear count, go to DEBOUNCE. col stays frozen.
  - No row low, or more than one row low (ghost/invalid): advance column index mod 4 (3 wraps to 0).
- DEBOUNCE state, on each tick:
  - Same single row still low: count+1.
  - When count reaches DEBOUNCE_TICKS: set key_code and pulse key_valid on the next clk, update bcd the same clk, go to HELD.
  - Any other row pattern: return to SCAN and advance the column.
- HELD state:
  - Count resets on every tick where the latched row is low.
  - Count increments on each tick where all rows are high.
  - At DEBOUNCE_TICKS consecutive release ticks: go to SCAN and advance the column.
  - Presses of other keys are ignored while in HELD.
- Key map, code = table[r][c]:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: E(*) 0 F(#) D
- bcd update on accept:
  - Codes 0-9: bcd <= {bcd[11:0], code}; the oldest digit is discarded, with no overflow flag.
  - F: clear, bcd <= 0.
  - E: backspace, bcd <= {4'h0, bcd[15:4]}.
  - A-D: bcd unchanged; key_code and key_valid are still reported.
- Latency: press stable at the pins -> key_valid is 2 sync clks plus DEBOUNCE_TICKS+1 ticks, ±1 tick of scan phase.
- Invariants: key_valid is never high on two consecutive clks. bcd nibbles are always 0-9.

Optional Feature:
- Macro: KEYPAD_AUTO_REPEAT_EN.
- Defined: in HELD, while the key stays pressed, a repeat counter runs.
  - First re-accept occurs after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
  - Each re-accept pulses key_valid with the same key_code and applies the bcd update again.
  - The repeat counter clears on entry to HELD and on any release tick.
- Not defined: no repeat counter is built. Exactly one key_valid per press.

Test Plan:
- Sim parameters: CLK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=6, REPEAT_RATE=2.
- Reset, no keys: col cycles 1110->1101->1011->0111->1110, one step every 4 clks. bcd=0000 and key_valid never pulses.
- Press 1,2,3,4,5 in sequence, each held 10 ticks and released 10 ticks: five key_valid pulses with key_code 1..5. Final bcd=16'h2345.
- Press 5 with row bouncing low/high on alternate ticks for 6 ticks, then stable: no key_valid during bounce, exactly one pulse after 3 stable ticks.
- With bcd=16'h2345: press * (E) -> bcd=16'h0234. Press # (F) -> bcd=16'h0000. Press A -> key_code=A, bcd unchanged.
- Two rows low simultaneously in the same column: no key_valid, col keeps advancing. Assert rst during DEBOUNCE: outputs return to reset values immediately.
- KEYPAD_AUTO_REPEAT_EN defined: hold 7 for 12 ticks after accept -> key_valid pulses at accept, +6, +8, +10, +12 ticks. bcd=16'h7777 from 0.
